// File: rtl/divider.sv
// Signed 64-bit restoring divider.
// A small control FSM sequences the operation while a separate datapath
// holds the operand magnitudes, performs one shift/subtract step per cycle
// and produces the sign-corrected, registered results.

// Control part: state register, iteration counter and step strobes
module divider_ctrl (
  input  logic clk,
  input  logic reset_n,
  input  logic op_start,
  input  logic op_clear,
  input  logic divisor_zero,
  output logic load_en,
  output logic step_en,
  output logic finish_en,
  output logic op_done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] count_q, count_d;

  // State and counter registers; reset returns to IDLE immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= 7'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and strobe decode; a zero divisor leaves EXEC after one cycle
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    load_en   = 1'b0;
    step_en   = 1'b0;
    finish_en = 1'b0;
    if (op_clear) begin
      state_d = IDLE;
      count_d = 7'd0;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = 7'd0;
          if (op_start) begin
            load_en = 1'b1;
            state_d = EXEC;
          end
        end
        EXEC: begin
          count_d = count_q + 7'd1;
          if (divisor_zero || (count_q == 7'd64)) begin
            finish_en = 1'b1;
            state_d   = DONE;
          end else begin
            step_en = 1'b1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
          count_d = 7'd0;
        end
      endcase
    end
  end

  // Result-valid flag is a direct decode of the DONE state register
  always_comb begin
    op_done = (state_q == DONE);
  end

endmodule

// Datapath part: operand magnitudes, restoring iteration and result registers
module divider_dp (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_clear,
  input  logic        load_en,
  input  logic        step_en,
  input  logic        finish_en,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic [63:0] quotient,
  output logic [63:0] remainder,
  output logic        div_by_zero,
  output logic        divisor_zero
);

  logic        dvd_neg_q, dvd_neg_d;
  logic        dvs_neg_q, dvs_neg_d;
  logic [63:0] dvs_mag_q, dvs_mag_d;
  logic [63:0] rem_q, rem_d;
  logic [63:0] quo_q, quo_d;
  logic [63:0] quotient_q, quotient_d;
  logic [63:0] remainder_q, remainder_d;
  logic        dbz_q, dbz_d;

  logic [64:0] shifted;
  logic [64:0] trial;
  logic [63:0] quo_neg;
  logic [63:0] rem_neg;

  // Datapath registers; everything reads zero straight out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      dvs_mag_q   <= 64'd0;
      rem_q       <= 64'd0;
      quo_q       <= 64'd0;
      quotient_q  <= 64'd0;
      remainder_q <= 64'd0;
      dbz_q       <= 1'b0;
    end else begin
      dvd_neg_q   <= dvd_neg_d;
      dvs_neg_q   <= dvs_neg_d;
      dvs_mag_q   <= dvs_mag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Shift/trial-subtract arithmetic and the two's-complement result negations
  always_comb begin
    shifted = {rem_q, quo_q[63]};
    trial   = shifted - {1'b0, dvs_mag_q};
    quo_neg = ~quo_q + 64'd1;
    rem_neg = ~rem_q + 64'd1;
  end

  // Working and result register updates; quo_q holds |dividend| until stepping
  always_comb begin
    dvd_neg_d   = dvd_neg_q;
    dvs_neg_d   = dvs_neg_q;
    dvs_mag_d   = dvs_mag_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    if (op_clear) begin
      rem_d       = 64'd0;
      quo_d       = 64'd0;
      quotient_d  = 64'd0;
      remainder_d = 64'd0;
      dbz_d       = 1'b0;
    end else if (load_en) begin
      dvd_neg_d   = dividend[63];
      dvs_neg_d   = divisor[63];
      dvs_mag_d   = divisor[63] ? (~divisor + 64'd1) : divisor;
      quo_d       = dividend[63] ? (~dividend + 64'd1) : dividend;
      rem_d       = 64'd0;
      quotient_d  = 64'd0;
      remainder_d = 64'd0;
      dbz_d       = 1'b0;
    end else if (step_en) begin
      if (!trial[64]) begin
        rem_d = trial[63:0];
        quo_d = {quo_q[62:0], 1'b1};
      end else begin
        rem_d = shifted[63:0];
        quo_d = {quo_q[62:0], 1'b0};
      end
    end else if (finish_en) begin
      if (divisor_zero) begin
        quotient_d  = 64'hFFFF_FFFF_FFFF_FFFF;
        remainder_d = dvd_neg_q ? quo_neg : quo_q;
        dbz_d       = 1'b1;
      end else begin
        quotient_d  = (dvd_neg_q ^ dvs_neg_q) ? quo_neg : quo_q;
        remainder_d = dvd_neg_q ? rem_neg : rem_q;
        dbz_d       = 1'b0;
      end
    end
  end

  // Result ports and the zero-divisor status seen by the control part
  always_comb begin
    quotient     = quotient_q;
    remainder    = remainder_q;
    div_by_zero  = dbz_q;
    divisor_zero = (dvs_mag_q == 64'd0);
  end

endmodule

// Top level: wires the control FSM to the datapath
module divider (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_start,
  input  logic        op_clear,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic [63:0] quotient,
  output logic [63:0] remainder,
  output logic        div_by_zero,
  output logic        op_done
);

  logic load_en;
  logic step_en;
  logic finish_en;
  logic divisor_zero;

  divider_ctrl u_ctrl (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .divisor_zero (divisor_zero),
    .load_en      (load_en),
    .step_en      (step_en),
    .finish_en    (finish_en),
    .op_done      (op_done)
  );

  divider_dp u_dp (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_clear     (op_clear),
    .load_en      (load_en),
    .step_en      (step_en),
    .finish_en    (finish_en),
    .dividend     (dividend),
    .divisor      (divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero),
    .divisor_zero (divisor_zero)
  );

endmodule
